turn_switch_conditioner: RTL and testbench
==========================================

TURN_SWITCH_CONDITIONER -- requirements
Module: turn_switch_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive stable clock edges required to accept a switch change; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port left_raw, input, 1, unsynchronized bouncing left turn switch.
REQ-005 SHALL have port right_raw, input, 1, unsynchronized bouncing right turn switch.
REQ-006 SHALL have port left, output, 1, debounced left level; feeds the turn-signal FSM left input.
REQ-007 SHALL have port right, output, 1, debounced right level; feeds the turn-signal FSM right input.
REQ-008 SHALL have port left_rise, output, 1, one-cycle pulse on each accepted left press.
REQ-009 SHALL have port right_rise, output, 1, one-cycle pulse on each accepted right press.

Function
REQ-010 SHALL process the left and right channels identically and independently, with no cross-channel interlock; both outputs high together is legal and passed through.
REQ-011 SHALL pass each raw input through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 SHALL implement a per-channel FSM with states IDLE (out 0), ARMING (out 0, counting), ACTIVE (out 1), RELEASING (out 1, counting).
REQ-013 SHALL transition IDLE->ARMING when s2=1, ACTIVE->RELEASING when s2=0; otherwise hold.
REQ-014 SHALL, in ARMING/RELEASING, increment a counter each edge while s2 differs from out, and return to IDLE/ACTIVE, clearing the counter, on any edge where s2 equals out (glitch rejection).
REQ-015 SHALL, when the counter equals DB_CYCLES-1 and s2 still differs from out, move to ACTIVE (from ARMING) or IDLE (from RELEASING) and clear the counter.
REQ-016 SHALL give a latency of exactly DB_CYCLES+1 edges: raw stable before edge 0 gives out changed after edge DB_CYCLES+1.
REQ-017 SHALL size the counter as $clog2(DB_CYCLES) bits; it never wraps, since it is cleared at DB_CYCLES-1.
REQ-018 SHALL assert *_rise for exactly the one cycle following the ARMING->ACTIVE edge; no pulse on release; a held switch produces exactly one pulse.
REQ-019 SHALL drive left/right and *_rise directly from registers, never combinationally from raw inputs.
REQ-020 SHALL reject any pulse or bounce shorter than DB_CYCLES stable s2 samples with no output change.

Reset
REQ-021 SHALL, while reset=1, immediately force s1=s2=0, FSM=IDLE, counter=0, and left=right=left_rise=right_rise=0, regardless of clk.
REQ-022 SHALL, on reset asserted mid-count or in ACTIVE, discard progress; after release a still-pressed switch needs a full DB_CYCLES+1 edges and then produces a fresh *_rise.

Structure
REQ-023 SHALL place the channel-state enum typedef (IDLE, ARMING, ACTIVE, RELEASING) and default DB_CYCLES constant in shared package turn_signal_pkg.
REQ-024 SHALL implement one channel (synchronizer, FSM, counter, rise pulse) as sub-module debounce_channel, instantiated twice.
REQ-025 SHALL fit in 120-400 lines of RTL in total.

Verification (DB_CYCLES=4, 100-time-unit clock, stimulus changed at negedge)
REQ-026 SHALL cover reset: reset=1 with left_raw=right_raw=1 -> all outputs 0; release reset -> left=right=1 after 5 edges, each *_rise high for one cycle.
REQ-027 SHALL cover clean press/release: left_raw 0->1 held 10 cycles then 0 -> left rises after edge 5, left_rise one cycle, left falls 5 edges after release, no second pulse.
REQ-028 SHALL cover bounce: right_raw pattern 1,0,1,1,0,1,1,1,1,1 per cycle -> right stays 0 until 4 consecutive s2 highs, then exactly one right_rise.
REQ-029 SHALL cover glitch: left_raw high for 3 cycles only -> left, left_rise stay 0 throughout.
REQ-030 SHALL cover simultaneous: both raw inputs rise same cycle -> left and right rise same edge, both rise pulses coincide.
REQ-031 SHALL cover mid-operation reset: reset pulsed during RELEASING with left_raw=1 -> left=0 immediately; new left_rise 5 edges after reset release.

Source files
------------

// File: rtl/turn_signal_pkg.sv
// turn_signal_pkg: shared channel-state encoding and default debounce depth
package turn_signal_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      ACTIVE,
      RELEASING
   } chan_state_t;

   localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronizer, debounce FSM and press pulse for one switch
module debounce_channel
   import turn_signal_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic s1, s2;
   logic [CW-1:0] cnt;
   chan_state_t state;

   // two-flop synchronizer for the asynchronous switch input
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end

   // debounce FSM; the edge that leaves IDLE/ACTIVE is the first stable sample, so the count starts at 1
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         rise <= 1'b0;
         case (state)
            IDLE:
               if (s2) begin
                  state <= ARMING;
                  cnt   <= CW'(1);
               end
            ARMING:
               if (!s2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= ACTIVE;
                  cnt   <= '0;
                  level <= 1'b1;
                  rise  <= 1'b1;
               end else
                  cnt <= cnt + 1'b1;
            ACTIVE:
               if (!s2) begin
                  state <= RELEASING;
                  cnt   <= CW'(1);
               end
            RELEASING:
               if (s2) begin
                  state <= ACTIVE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  level <= 1'b0;
               end else
                  cnt <= cnt + 1'b1;
            default: begin
               state <= IDLE;
               cnt   <= '0;
               level <= 1'b0;
            end
         endcase
      end

endmodule

// File: rtl/turn_switch_conditioner.sv
// turn_switch_conditioner: independent debounce of the left and right turn switches
module turn_switch_conditioner
   import turn_signal_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic left_raw,
   input  logic right_raw,
   output logic left,
   output logic right,
   output logic left_rise,
   output logic right_rise
);

   debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_left (
      .clk  (clk),
      .reset(reset),
      .raw  (left_raw),
      .level(left),
      .rise (left_rise)
   );

   debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_right (
      .clk  (clk),
      .reset(reset),
      .raw  (right_raw),
      .level(right),
      .rise (right_rise)
   );

endmodule

// File: tb/tb_turn_switch_conditioner.sv
// tb_turn_switch_conditioner: scoreboard bench against a run-length reference model
module tb_turn_switch_conditioner;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic left_raw = 1'b0;
   logic right_raw = 1'b0;
   logic left, right, left_rise, right_rise;

   int tests = 0;
   int fails = 0;
   int lr_seen = 0;
   int rr_seen = 0;
   logic [3:0] exp_q[$];

   logic ms1[2], ms2[2], mout[2], mrise[2];
   int run[2];
   logic [1:0] mraw;

   turn_switch_conditioner #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .left_raw  (left_raw),
      .right_raw (right_raw),
      .left      (left),
      .right     (right),
      .left_rise (left_rise),
      .right_rise(right_rise)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial
      for (int c = 0; c < 2; c++) begin
         ms1[c] = 0; ms2[c] = 0; mout[c] = 0; mrise[c] = 0; run[c] = 0;
      end

   // reference: output flips once DB consecutive synchronized samples disagree with it
   always @(posedge clk) begin
      mraw = {right_raw, left_raw};
      for (int c = 0; c < 2; c++) begin
         if (reset) begin
            ms1[c] = 0; ms2[c] = 0; mout[c] = 0; mrise[c] = 0; run[c] = 0;
         end else begin
            mrise[c] = 0;
            if (ms2[c] != mout[c]) begin
               run[c]++;
               if (run[c] == DB) begin
                  mout[c] = ~mout[c];
                  mrise[c] = mout[c];
                  run[c] = 0;
               end
            end else
               run[c] = 0;
            ms2[c] = ms1[c];
            ms1[c] = mraw[c];
         end
      end
      exp_q.push_back({mrise[1], mrise[0], mout[1], mout[0]});
      #10;
      if (exp_q.size() == 0)
         chk("queue_empty", 0, 1);
      else
         chk("outputs", {28'd0, right_rise, left_rise, right, left}, {28'd0, exp_q.pop_front()});
      lr_seen += int'(left_rise);
      rr_seen += int'(right_rise);
   end

   int lb, rb;
   logic pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

   initial begin
      reset = 1'b1; left_raw = 1'b1; right_raw = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("reset_outputs", {28'd0, right_rise, left_rise, right, left}, 0);
      lb = lr_seen; rb = rr_seen;
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("reset_release_levels", {30'd0, right, left}, 3);
      chk("reset_release_lrise", lr_seen - lb, 1);
      chk("reset_release_rrise", rr_seen - rb, 1);
      left_raw = 1'b0; right_raw = 1'b0;
      repeat (8) @(negedge clk);
      chk("release_levels", {30'd0, right, left}, 0);

      lb = lr_seen;
      left_raw = 1'b1;
      repeat (10) @(negedge clk);
      left_raw = 1'b0;
      repeat (8) @(negedge clk);
      chk("clean_press_pulses", lr_seen - lb, 1);
      chk("clean_release_level", left, 0);

      rb = rr_seen;
      for (int i = 0; i < 10; i++) begin
         right_raw = pat[i];
         @(negedge clk);
      end
      repeat (6) @(negedge clk);
      chk("bounce_pulses", rr_seen - rb, 1);
      chk("bounce_level", right, 1);
      right_raw = 1'b0;
      repeat (8) @(negedge clk);

      lb = lr_seen;
      left_raw = 1'b1;
      repeat (3) @(negedge clk);
      left_raw = 1'b0;
      repeat (8) @(negedge clk);
      chk("glitch_pulses", lr_seen - lb, 0);
      chk("glitch_level", left, 0);

      lb = lr_seen; rb = rr_seen;
      left_raw = 1'b1; right_raw = 1'b1;
      repeat (8) @(negedge clk);
      chk("simul_lpulses", lr_seen - lb, 1);
      chk("simul_rpulses", rr_seen - rb, 1);
      left_raw = 1'b0; right_raw = 1'b0;
      repeat (8) @(negedge clk);

      left_raw = 1'b1;
      repeat (8) @(negedge clk);
      chk("pre_reset_active", left, 1);
      left_raw = 1'b0;
      repeat (3) @(negedge clk);
      left_raw = 1'b1;
      reset = 1'b1;
      #1 chk("mid_reset_immediate", {28'd0, right_rise, left_rise, right, left}, 0);
      repeat (2) @(negedge clk);
      lb = lr_seen;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_reset_early", left, 0);
      repeat (2) @(negedge clk);
      chk("post_reset_level", left, 1);
      chk("post_reset_pulse", lr_seen - lb, 1);
      left_raw = 1'b0;
      repeat (8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
